apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB4 requester that drives the timer's APB slave port (tim_psel/tim_penable/tim_pwrite/tim_paddr/tim_pwdata/tim_pstrb) from a simple valid/ready command interface.
- Returns read data and error status on a valid/ready response interface.
- Serves as the CPU-side or testbench-side initiator for timer register access.
- Includes a programmable wait-state timeout so a hung slave cannot stall the requester.

Parameters:
ADDR_W, 12, APB address width
DATA_W, 32, APB data width (strobe width = DATA_W/8)
TIMEOUT, 255, max ACCESS cycles without pready before abort; 0 = timeout disabled

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  bridge can accept command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  target address
cmd_wdata  input  DATA_W  write data
cmd_strb  input  DATA_W/8  write byte strobes
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  DATA_W  read data (0 for writes)
rsp_err  output  1  pslverr seen or timeout
rsp_timeout  output  1  response ended by timeout
busy  output  1  transfer in progress (state != IDLE)
tim_psel  output  1  APB select
tim_penable  output  1  APB enable
tim_pwrite  output  1  APB direction
tim_paddr  output  ADDR_W  APB address
tim_pwdata  output  DATA_W  APB write data
tim_pstrb  output  DATA_W/8  APB strobes
tim_pready  input  1  slave ready
tim_pslverr  input  1  slave error
tim_prdata  input  DATA_W  slave read data

Behaviour:
- Reset (async, sys_rst_n low): state = IDLE; all outputs 0 except cmd_ready = 1; wait counter = 0. Reset mid-transfer drops tim_psel and tim_penable immediately (asynchronously) and discards any pending response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, register cmd_* into tim_paddr/tim_pwrite/tim_pwdata/tim_pstrb and go to SETUP.
  - tim_pstrb is forced to 0 when cmd_write = 0.
- SETUP (exactly 1 cycle): tim_psel = 1, tim_penable = 0. Always go to ACCESS.
- ACCESS: tim_psel = 1, tim_penable = 1. Wait counter increments each cycle tim_pready = 0.
  - If tim_pready = 1: capture rsp_rdata = tim_prdata for reads (0 for writes), rsp_err = tim_pslverr, rsp_timeout = 0. Go to RESP.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0. Go to RESP.
  - tim_pready has priority when it arrives on the timeout cycle.
- RESP:
  - tim_psel = 0, tim_penable = 0, rsp_valid = 1.
  - rsp_* fields are held stable while rsp_ready = 0.
  - On rsp_ready = 1, clear rsp_valid and go to IDLE. Counter clears on SETUP entry.
- cmd_ready = 0 in SETUP, ACCESS and RESP. Commands are not queued; cmd_* values are ignored outside the accept cycle.
- tim_paddr, tim_pwrite, tim_pwdata and tim_pstrb are stable from SETUP through the final ACCESS cycle. They hold their last values in RESP and IDLE (no toggling).
- tim_pslverr and tim_prdata are sampled only in the cycle where tim_penable & tim_pready.
- Latency: command accepted at cycle T; SETUP at T+1; first ACCESS at T+2. With zero wait states rsp_valid rises at T+3. Minimum turnaround between commands is 4 cycles with rsp_ready tied high.
- Wait counter width is clog2(TIMEOUT+1), minimum 1; it saturates and never wraps.

Test Plan:
- Write, zero wait: cmd write addr 0x004, wdata 0x0000_0003, strb 0xF, tim_pready tied 1 -> tim_psel rises T+1, tim_penable rises T+2 with paddr 0x004, pstrb 0xF; rsp_valid at T+3 with rsp_err = 0, rsp_rdata = 0.
- Read, 3 wait states: cmd read addr 0x010, strb 0xF; tim_pready low for 3 ACCESS cycles then high with prdata 0x1234_5678 -> tim_pstrb = 0 throughout, ACCESS lasts 4 cycles, rsp_rdata = 0x1234_5678, rsp_err = 0.
- Slave error: write addr 0xFFC; tim_pready = 1 with tim_pslverr = 1 -> rsp_err = 1, rsp_timeout = 0, FSM returns to IDLE after rsp_ready.
- Timeout: TIMEOUT = 4, tim_pready held 0 -> exactly 4 ACCESS cycles, then psel/penable drop; rsp_err = 1, rsp_timeout = 1. Repeat with tim_pready rising in the 4th cycle -> normal completion, rsp_timeout = 0.
- Backpressure: read completes with rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready = 0 and a second cmd_valid is not accepted; after rsp_ready, cmd_ready = 1 next cycle.
- Reset mid-ACCESS: assert sys_rst_n low during the 2nd wait cycle -> tim_psel, tim_penable and rsp_valid go 0 without a clock edge; after release, cmd_ready = 1 and a new write completes normally.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Signal bundle for apb_master_bridge: command/response handshakes, the APB4
// requester pins toward the timer, and an FSM state view for checkers.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // Handshakes: a transfer happens on a rising clock edge where valid and ready
  // are both high; once valid is raised its payload stays stable until that edge.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              busy;
  logic [1:0]        dbg_state;

  logic              tim_psel;
  logic              tim_penable;
  logic              tim_pwrite;
  logic [ADDR_W-1:0] tim_paddr;
  logic [DATA_W-1:0] tim_pwdata;
  logic [STRB_W-1:0] tim_pstrb;
  logic              tim_pready;
  logic              tim_pslverr;
  logic [DATA_W-1:0] tim_prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
    input  tim_pready, tim_pslverr, tim_prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy, dbg_state,
    output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
    output tim_pready, tim_pslverr, tim_prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy, dbg_state,
    input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB4 requester: turns one valid/ready command into a SETUP/ACCESS transfer
// and returns data/error on a valid/ready response, with a wait-state timeout.
module apb_master_bridge #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  apb_master_bridge_if.master bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TO_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;

  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic              cmd_ready;
  logic              psel;
  logic              penable;
  logic              rsp_valid;
  logic              busy;

  logic              cmd_fire;
  logic              done_ok;
  logic              done_to;

  assign cmd_fire = (state_q == S_IDLE) && bus.cmd_valid;
  assign done_ok  = (state_q == S_ACCESS) && bus.tim_pready;
  // A slave answer on the last allowed cycle wins over the abort.
  assign done_to  = (state_q == S_ACCESS) && !bus.tim_pready && TO_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cmd_fire) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (done_ok || done_to) state_d = S_RESP;
      S_RESP:   if (bus.rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_SETUP: begin
        psel = 1'b1;
      end
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Request fields load only on acceptance, so they hold through RESP and IDLE.
  always_comb begin
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    if (cmd_fire) begin
      pwrite_d = bus.cmd_write;
      paddr_d  = bus.cmd_addr;
      pwdata_d = bus.cmd_wdata;
      pstrb_d  = bus.cmd_write ? bus.cmd_strb : '0;
    end
  end

  // Saturating wait-state counter, cleared as SETUP is entered.
  always_comb begin
    cnt_d = cnt_q;
    if (cmd_fire) begin
      cnt_d = '0;
    end else if ((state_q == S_ACCESS) && !bus.tim_pready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Response fields only change on the ACCESS exit, which keeps them stable in RESP.
  always_comb begin
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    if (done_ok) begin
      rsp_rdata_d   = pwrite_q ? '0 : bus.tim_prdata;
      rsp_err_d     = bus.tim_pslverr;
      rsp_timeout_d = 1'b0;
    end else if (done_to) begin
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q         <= '0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.busy        = busy;
  assign bus.dbg_state   = state_q;

  assign bus.tim_psel    = psel;
  assign bus.tim_penable = penable;
  assign bus.tim_pwrite  = pwrite_q;
  assign bus.tim_paddr   = paddr_q;
  assign bus.tim_pwdata  = pwdata_q;
  assign bus.tim_pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge (TIMEOUT = 4): vector table of complete APB
// transfers plus hand sequences for response backpressure and mid-transfer reset.
module tb_apb_master_bridge;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    int          exp_access;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    logic [3:0]  exp_pstrb;
  } vec_t;

  vec_t  vecs[8];
  int    checks   = 0;
  int    failures = 0;
  string cur_tag  = "init";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur_tag, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_wdata   = '0;
    bus.cmd_strb    = '0;
    bus.rsp_ready   = 1'b0;
    bus.tim_pready  = 1'b0;
    bus.tim_pslverr = 1'b0;
    bus.tim_prdata  = '0;
  endtask

  // Slave answers after v.waits ACCESS cycles; non-ready cycles carry junk data/error.
  task automatic run_vec(input vec_t v);
    int   n;
    logic stable;
    check("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_strb  = v.strb;
    bus.rsp_ready = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = ~v.wr;
    bus.cmd_addr  = ~v.addr;
    bus.cmd_wdata = ~v.wdata;
    bus.cmd_strb  = ~v.strb;
    check("setup_psel", bus.tim_psel, 1);
    check("setup_penable", bus.tim_penable, 0);
    check("setup_cmd_ready", bus.cmd_ready, 0);
    check("setup_paddr", bus.tim_paddr, v.addr);
    check("setup_pwrite", bus.tim_pwrite, v.wr);
    check("setup_pwdata", bus.tim_pwdata, v.wdata);
    check("setup_pstrb", bus.tim_pstrb, v.exp_pstrb);
    tick();
    n = 0;
    stable = 1'b1;
    while (bus.tim_psel && bus.tim_penable && n < 16) begin
      if (bus.tim_paddr !== v.addr || bus.tim_pwrite !== v.wr ||
          bus.tim_pwdata !== v.wdata || bus.tim_pstrb !== v.exp_pstrb) stable = 1'b0;
      bus.tim_pready  = (n == v.waits);
      bus.tim_prdata  = (n == v.waits) ? v.prdata : (32'h5555_5555 ^ 32'(n));
      bus.tim_pslverr = (n == v.waits) ? v.slverr : 1'b1;
      n++;
      tick();
    end
    bus.tim_pready  = 1'b0;
    bus.tim_pslverr = 1'b0;
    bus.tim_prdata  = '0;
    check("access_cycles", 32'(n), 32'(v.exp_access));
    check("access_stable", stable, 1);
    check("resp_valid", bus.rsp_valid, 1);
    check("resp_psel", bus.tim_psel, 0);
    check("resp_penable", bus.tim_penable, 0);
    check("resp_rdata", bus.rsp_rdata, v.exp_rdata);
    check("resp_err", bus.rsp_err, v.exp_err);
    check("resp_timeout", bus.rsp_timeout, v.exp_to);
    check("resp_busy", bus.busy, 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("done_rsp_valid", bus.rsp_valid, 0);
    check("done_cmd_ready", bus.cmd_ready, 1);
    check("done_busy", bus.busy, 0);
    check("done_pstrb_hold", bus.tim_pstrb, v.exp_pstrb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             wr    addr     wdata         strb  wt err  prdata        acc rdata         err   to    pstrb
    vecs[0] = '{1'b1, 12'h004, 32'h0000_0003, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 1, 32'h0,        1'b0, 1'b0, 4'hF};
    vecs[1] = '{1'b0, 12'h010, 32'h0,         4'hF, 3, 1'b0, 32'h1234_5678, 4, 32'h1234_5678, 1'b0, 1'b0, 4'h0};
    vecs[2] = '{1'b1, 12'hFFC, 32'hA5A5_A5A5, 4'h3, 0, 1'b1, 32'h0,         1, 32'h0,        1'b1, 1'b0, 4'h3};
    vecs[3] = '{1'b0, 12'h020, 32'h0,         4'hF, 9, 1'b0, 32'h0000_CAFE, 4, 32'h0,        1'b1, 1'b1, 4'h0};
    vecs[4] = '{1'b0, 12'h100, 32'h0,         4'hF, 1, 1'b1, 32'h0BAD_F00D, 2, 32'h0BAD_F00D, 1'b1, 1'b0, 4'h0};
    vecs[5] = '{1'b1, 12'h7F0, 32'h1122_3344, 4'h5, 2, 1'b0, 32'hFFFF_0000, 3, 32'h0,        1'b0, 1'b0, 4'h5};
    vecs[6] = '{1'b1, 12'h008, 32'h0000_0001, 4'hF, 9, 1'b0, 32'h0,         4, 32'h0,        1'b1, 1'b1, 4'hF};
    vecs[7] = '{1'b0, 12'hABC, 32'h0,         4'h0, 0, 1'b0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0};

    idle_inputs();
    repeat (3) tick();
    cur_tag = "reset";
    check("cmd_ready", bus.cmd_ready, 1);
    check("psel", bus.tim_psel, 0);
    check("penable", bus.tim_penable, 0);
    check("rsp_valid", bus.rsp_valid, 0);
    check("rsp_err", bus.rsp_err, 0);
    check("rsp_timeout", bus.rsp_timeout, 0);
    check("rsp_rdata", bus.rsp_rdata, 0);
    check("paddr", bus.tim_paddr, 0);
    check("pstrb", bus.tim_pstrb, 0);
    check("busy", bus.busy, 0);
    check("state", bus.dbg_state, 0);
    sys_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end

    // Response held for 5 cycles while a second command is offered.
    cur_tag = "backpressure";
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 12'h040;
    bus.cmd_strb  = 4'hF;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.tim_pready = 1'b1;
    bus.tim_prdata = 32'h89AB_CDEF;
    tick();
    bus.tim_pready = 1'b0;
    bus.tim_prdata = '0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold_valid%0d", k), bus.rsp_valid, 1);
      check($sformatf("hold_rdata%0d", k), bus.rsp_rdata, 32'h89AB_CDEF);
      check($sformatf("hold_cmd_ready%0d", k), bus.cmd_ready, 0);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 12'h123;
      tick();
    end
    check("still_valid", bus.rsp_valid, 1);
    check("no_second_psel", bus.tim_psel, 0);
    check("paddr_unchanged", bus.tim_paddr, 12'h040);
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b0;
    tick();
    bus.rsp_ready = 1'b0;
    check("after_cmd_ready", bus.cmd_ready, 1);
    check("after_rsp_valid", bus.rsp_valid, 0);
    check("after_psel", bus.tim_psel, 0);

    // Reset pulled in the 2nd wait-state cycle, between clock edges.
    cur_tag = "reset_mid";
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 12'h0C0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check("pre_psel", bus.tim_psel, 1);
    check("pre_penable", bus.tim_penable, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_psel", bus.tim_psel, 0);
    check("async_penable", bus.tim_penable, 0);
    check("async_rsp_valid", bus.rsp_valid, 0);
    check("async_cmd_ready", bus.cmd_ready, 1);
    check("async_busy", bus.busy, 0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    cur_tag = "after_reset_write";
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
